// File: rtl/ice_tx_frame_arbiter.sv
// Frame-atomic arbiter sharing one UART TX character channel among NUM_SRC frame sources.
// Define ICE_TX_ARB_NAK_PRIORITY_EN to give source 0 (NAK generator) strict priority.
module ice_tx_frame_arbiter #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned SRC_W   = 3,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*NUM_SRC-1:0] src_char,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [7:0]           tx_char,
  output logic                 tx_char_valid,
  input  logic                 tx_char_ready,
  output logic [NUM_SRC-1:0]   grant,
  output logic                 busy,
  output logic                 abort_pulse,
  output logic [SRC_W-1:0]     abort_id,
  output logic [15:0]          frame_count
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   sel_q, sel_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [15:0]        wd_q, wd_d;
  logic               abort_pulse_q, abort_pulse_d;
  logic [SRC_W-1:0]   abort_id_q, abort_id_d;
  logic [15:0]        frame_count_q, frame_count_d;

  logic [7:0]         sel_char;
  logic               sel_valid;
  logic               sel_last;
  logic               xfer;
  logic [NUM_SRC-1:0] req_rr;
  logic               found;
  logic [SRC_W-1:0]   pick;
  logic [NUM_SRC-1:0] pick_oh;
  logic               wd_expired;

  assign busy = (state_q == StActive);

  // Mux of the owning source's lanes
  always_comb begin
    sel_char  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (SRC_W'(i) == sel_q) begin
        sel_char  = src_char[8*i +: 8];
        sel_valid = src_valid[i];
        sel_last  = src_last[i];
      end
    end
  end

  assign tx_char       = busy ? sel_char : 8'h00;
  assign tx_char_valid = busy & sel_valid;
  assign src_ready     = busy ? (grant_q & {NUM_SRC{tx_char_ready}}) : '0;
  assign xfer          = tx_char_valid & tx_char_ready;

  // Round-robin search starting just above rr_ptr, wrapping modulo NUM_SRC
  always_comb begin
    int unsigned idx;
    idx     = 0;
    found   = 1'b0;
    pick    = '0;
    pick_oh = '0;
`ifdef ICE_TX_ARB_NAK_PRIORITY_EN
    req_rr = src_valid & ~NUM_SRC'(1);
    if (src_valid[0]) begin
      found      = 1'b1;
      pick_oh[0] = 1'b1;
    end
`else
    req_rr = src_valid;
`endif
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_SRC;
      if (!found && req_rr[idx]) begin
        found        = 1'b1;
        pick         = SRC_W'(idx);
        pick_oh[idx] = 1'b1;
      end
    end
  end

  assign wd_expired = (TIMEOUT != 0) && (wd_q == 16'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    wd_d          = wd_q;
    abort_pulse_d = 1'b0;
    abort_id_d    = abort_id_q;
    frame_count_d = frame_count_q;
    unique case (state_q)
      StIdle: begin
        wd_d = '0;
        if (found) begin
          sel_d   = pick;
          grant_d = pick_oh;
          state_d = StActive;
        end
      end
      StActive: begin
        wd_d = xfer ? 16'd0 : wd_q + 16'd1;
        if (xfer && sel_last) begin
          state_d       = StIdle;
          grant_d       = '0;
          wd_d          = '0;
          frame_count_d = frame_count_q + 16'd1;
`ifdef ICE_TX_ARB_NAK_PRIORITY_EN
          if (sel_q != '0) rr_ptr_d = sel_q;
`else
          rr_ptr_d = sel_q;
`endif
        end else if (wd_expired && !xfer) begin
          state_d       = StIdle;
          grant_d       = '0;
          wd_d          = '0;
          abort_pulse_d = 1'b1;
          abort_id_d    = sel_q;
`ifdef ICE_TX_ARB_NAK_PRIORITY_EN
          if (sel_q != '0) rr_ptr_d = sel_q;
`else
          rr_ptr_d = sel_q;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      sel_q         <= '0;
      grant_q       <= '0;
      rr_ptr_q      <= SRC_W'(NUM_SRC - 1);
      wd_q          <= '0;
      abort_pulse_q <= 1'b0;
      abort_id_q    <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      wd_q          <= wd_d;
      abort_pulse_q <= abort_pulse_d;
      abort_id_q    <= abort_id_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign grant       = grant_q;
  assign abort_pulse = abort_pulse_q;
  assign abort_id    = abort_id_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ice_tx_frame_arbiter.sv
// Directed bench for ice_tx_frame_arbiter; a small per-source frame model drives the inputs.
module tb_ice_tx_frame_arbiter;
`ifdef ICE_TX_ARB_NAK_PRIORITY_EN
  localparam int NS = 3;
`else
  localparam int NS = 2;
`endif
  localparam int SW = 3;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [8*NS-1:0] src_char;
  logic [NS-1:0]   src_valid;
  logic [NS-1:0]   src_last;
  logic [NS-1:0]   src_ready;
  logic [7:0]      tx_char;
  logic            tx_char_valid;
  logic            tx_char_ready;
  logic [NS-1:0]   grant;
  logic            busy;
  logic            abort_pulse;
  logic [SW-1:0]   abort_id;
  logic [15:0]     frame_count;

  ice_tx_frame_arbiter #(
    .NUM_SRC(NS),
    .SRC_W  (SW),
    .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_char     (src_char),
    .src_valid    (src_valid),
    .src_last     (src_last),
    .src_ready    (src_ready),
    .tx_char      (tx_char),
    .tx_char_valid(tx_char_valid),
    .tx_char_ready(tx_char_ready),
    .grant        (grant),
    .busy         (busy),
    .abort_pulse  (abort_pulse),
    .abort_id     (abort_id),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Source model: nfr frames of flen chars, char = base + position; cap mutes the source early
  int         nfr[NS];
  int         flen[NS];
  int         pos[NS];
  int         cap[NS];
  logic [7:0] base[NS];
  logic [7:0] log_chr[$];
  int         log_cyc[$];
  int         cyc_n = 0;

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      src_valid[i]       = (nfr[i] > 0) && (pos[i] < cap[i]);
      src_char[8*i +: 8] = base[i] + 8'(pos[i]);
      src_last[i]        = (pos[i] == flen[i] - 1);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NS; i++) begin
      nfr[i]  = 0;
      flen[i] = 1;
      pos[i]  = 0;
      cap[i]  = 99;
      base[i] = 8'h00;
    end
    log_chr.delete();
    log_cyc.delete();
    drive();
  endtask

  task automatic cyc();
    logic [NS-1:0] fire;
    fire = src_ready & src_valid;
    if (tx_char_valid && tx_char_ready) begin
      log_chr.push_back(tx_char);
      log_cyc.push_back(cyc_n);
    end
    @(posedge clk);
    #1;
    cyc_n++;
    for (int i = 0; i < NS; i++) begin
      if (fire[i]) begin
        if (src_last[i]) begin
          pos[i] = 0;
          nfr[i]--;
        end else begin
          pos[i]++;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] lc(int k);
    return (k < log_chr.size()) ? log_chr[k] : 8'h00;
  endfunction

  function automatic int lcy(int k);
    return (k < log_cyc.size()) ? log_cyc[k] : -1;
  endfunction

  initial begin
    int np;
    tx_char_ready = 1'b1;
    clear_model();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    // Reset state
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_abort", abort_pulse, 0);
    check("rst_abort_id", abort_id, 0);
    check("rst_fcount", frame_count, 0);
    check("rst_txchar", tx_char, 0);
    check("rst_src_ready", src_ready, 0);

    // Basic 4-char frame from src1
    nfr[1] = 1; flen[1] = 4; base[1] = 8'h10;
    drive();
    #1;
    check("bas_grant_pre", grant, 0);
    cyc();
    check("bas_grant", grant, 2);
    check("bas_busy", busy, 1);
    repeat (4) cyc();
    check("bas_grant_end", grant, 0);
    check("bas_fcount", frame_count, 1);
    check("bas_nchars", log_chr.size(), 4);
    check("bas_chars", {lc(0), lc(1), lc(2), lc(3)}, 32'h10111213);
    check("bas_consec", lcy(3) - lcy(0), 3);

`ifndef ICE_TX_ARB_NAK_PRIORITY_EN
    // Round-robin between src0 and src1, two 2-char frames each
    do_reset();
    nfr[0] = 2; flen[0] = 2; base[0] = 8'h20;
    nfr[1] = 2; flen[1] = 2; base[1] = 8'h30;
    drive();
    #1;
    for (int k = 0; k < 40 && frame_count != 16'd4; k++) cyc();
    check("rr_fcount", frame_count, 4);
    check("rr_nchars", log_chr.size(), 8);
    check("rr_chars_a", {lc(0), lc(1), lc(2), lc(3)}, 32'h20213031);
    check("rr_chars_b", {lc(4), lc(5), lc(6), lc(7)}, 32'h20213031);
    check("rr_in_frame", lcy(1) - lcy(0), 1);
    check("rr_gap", lcy(2) - lcy(1), 2);
`endif

    // Backpressure: ready 1,0,0,1 across a 2-char frame
    do_reset();
    nfr[1] = 1; flen[1] = 2; base[1] = 8'h40;
    drive();
    #1;
    cyc();
    check("bp_rdy1", src_ready, 2);
    cyc();
    tx_char_ready = 1'b0;
    #1;
    check("bp_rdy0a", src_ready, 0);
    check("bp_hold", {tx_char_valid, tx_char}, {1'b1, 8'h41});
    cyc();
    check("bp_rdy0b", src_ready, 0);
    cyc();
    tx_char_ready = 1'b1;
    #1;
    check("bp_rdy1b", src_ready, 2);
    cyc();
    check("bp_chars", {log_chr.size(), lc(0), lc(1)}, {16'd2, 8'h40, 8'h41});
    check("bp_fcount", frame_count, 1);
    check("bp_noabort", abort_pulse, 0);

    // Watchdog: src0 sends one char then goes silent; src1 waits
    do_reset();
    nfr[0] = 1; flen[0] = 4; cap[0] = 1; base[0] = 8'h50;
    drive();
    #1;
    cyc();
    nfr[1] = 1; flen[1] = 1; base[1] = 8'h70;
    drive();
    #1;
    cyc();
    np = 0;
    repeat (7) begin
      cyc();
      np += int'(abort_pulse);
    end
    check("wd_early", np, 0);
    check("wd_grant_held", grant, 1);
    cyc();
    check("wd_pulse", abort_pulse, 1);
    check("wd_id", abort_id, 0);
    check("wd_fcount", frame_count, 0);
    check("wd_grant_clr", grant, 0);
    cyc();
    check("wd_next_grant", grant, 2);
    check("wd_pulse_1cyc", abort_pulse, 0);
    check("wd_id_held", abort_id, 0);
    cyc();
    check("wd_src1_done", frame_count, 1);

    // Reset during the 2nd char of a 5-char frame
    nfr[1] = 1; flen[1] = 5; base[1] = 8'h60;
    drive();
    #1;
    cyc();
    cyc();
    check("rmf_char2", tx_char, 8'h61);
    rst = 1'b1;
    cyc();
    check("rmf_grant", grant, 0);
    check("rmf_busy", busy, 0);
    check("rmf_fcount", frame_count, 0);
    check("rmf_abort", abort_pulse, 0);
    rst = 1'b0;
    clear_model();

`ifdef ICE_TX_ARB_NAK_PRIORITY_EN
    // src0 arrives while src1 owns a frame; it goes next, ahead of src2
    do_reset();
    nfr[1] = 3; flen[1] = 2; base[1] = 8'h80;
    nfr[2] = 3; flen[2] = 2; base[2] = 8'h90;
    drive();
    #1;
    cyc();
    check("nak_first", grant, 2);
    nfr[0] = 1; flen[0] = 1; base[0] = 8'hA0;
    drive();
    #1;
    check("nak_no_preempt", grant, 2);
    for (int k = 0; k < 30 && log_chr.size() < 5; k++) cyc();
    check("nak_order", {lc(0), lc(1), lc(2), lc(3)}, 32'h8081A090);
    check("nak_tail", lc(4), 8'h91);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
